// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART.
//   Register word indices (wb_adr_i[3:2]), STATUS bit positions,
//   and the state encoding used by both the TX and RX serial FSMs.
package uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;  // TXDATA on write, RXDATA on read
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_SCRATCH = 2'd2;

  localparam int unsigned STAT_TX_BUSY   = 0;
  localparam int unsigned STAT_RX_VALID  = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver.
//   clk, rst     : system clock, asynchronous active-high reset
//   i_rx         : asynchronous serial input, idle high
//   o_done       : one-cycle strobe on the stop-bit sample
//   o_byte       : received byte, valid while o_done is high
//   o_stop_err   : stop bit sampled low, valid while o_done is high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_done,
  output logic [7:0] o_byte,
  output logic       o_stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_prev;
  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync0 <= i_rx;
      r_sync1 <= r_sync0;
      r_prev  <= r_sync1;
      case (r_state)
        S_IDLE: begin
          // Edge rather than level, so a line still low after a bad
          // stop bit is not mistaken for a new start bit.
          if (r_prev && !r_sync1) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == HALF) begin
            r_cnt <= '0;
            if (r_sync1) begin
              r_state <= S_IDLE;   // glitch: line back high at mid-start
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync1, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Completion is reported on the stop-sample edge itself so the register
  // block captures the byte in the same cycle the stop bit is judged.
  assign o_done     = (r_state == S_STOP) && (r_cnt == LAST);
  assign o_byte     = r_shift;
  assign o_stop_err = ~r_sync1;

endmodule

// File: rtl/wb_uart.sv
// Wishbone-classic slave UART (8N1) with a four-word register window.
//   clk, rst               : system clock, asynchronous active-high reset
//   wb_adr_i[3:2]          : word select (DATA, STATUS, SCRATCH, unused)
//   wb_dat_i / wb_dat_o    : write data / combinational read data
//   wb_we_i, wb_stb_i,
//   wb_cyc_i, wb_ack_o     : classic handshake, ack registered one cycle later
//   tx                     : serial output, idle high
//   rx                     : asynchronous serial input, idle high
module wb_uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        tx,
  input  logic        rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          w_req;
  logic          w_wr;
  logic          w_rd;
  logic [1:0]    w_sel;
  logic          w_tx_busy;
  logic          w_tx_start;
  logic          w_rx_done;
  logic [7:0]    w_rx_byte;
  logic          w_rx_stop_err;

  logic          r_ack;
  logic          r_tx;
  uart_state_t   r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic [7:0]    r_rxdata;
  logic          r_rx_valid;
  logic          r_overrun;
  logic          r_frame_err;
  logic [15:0]   r_scratch;

  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_wr       = w_req & wb_we_i;
  assign w_rd       = w_req & ~wb_we_i;
  assign w_sel      = wb_adr_i[3:2];
  assign w_tx_busy  = (r_tx_state != S_IDLE);
  assign w_tx_start = w_wr && (w_sel == REG_DATA) && !w_tx_busy;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (rx),
    .o_done     (w_rx_done),
    .o_byte     (w_rx_byte),
    .o_stop_err (w_rx_stop_err)
  );

  // Bus handshake and register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack       <= 1'b0;
      r_rxdata    <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_scratch   <= '0;
    end else begin
      r_ack <= w_req;
      if (w_wr && (w_sel == REG_SCRATCH)) r_scratch <= wb_dat_i[15:0];
      if (w_rx_done) r_rxdata <= w_rx_byte;
      // A byte landing in the same cycle as a data read keeps valid set.
      if (w_rx_done)                            r_rx_valid <= 1'b1;
      else if (w_rd && (w_sel == REG_DATA))     r_rx_valid <= 1'b0;
      if (w_rx_done && r_rx_valid)              r_overrun  <= 1'b1;
      else if (w_wr && (w_sel == REG_STATUS) && wb_dat_i[STAT_OVERRUN])
                                                r_overrun  <= 1'b0;
      if (w_rx_done && w_rx_stop_err)           r_frame_err <= 1'b1;
      else if (w_wr && (w_sel == REG_STATUS) && wb_dat_i[STAT_FRAME_ERR])
                                                r_frame_err <= 1'b0;
    end
  end

  // Transmit FSM: each state holds for CLKS_PER_BIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (w_tx_start) begin
            r_tx_state <= S_START;
            r_tx_cnt   <= '0;
            r_tx       <= 1'b0;
          end
        end
        S_START: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= S_DATA;
            r_tx       <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx       <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              // Shift register moves on this same edge, so bit 1 is next.
              r_tx     <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt   <= '0;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // Outgoing byte: pure data, loaded on start and shifted per data bit
  always_ff @(posedge clk) begin
    if (w_tx_start) begin
      r_tx_shift <= wb_dat_i[7:0];
    end else if ((r_tx_state == S_DATA) && (r_tx_cnt == LAST)) begin
      r_tx_shift <= {1'b0, r_tx_shift[7:1]};
    end
  end

  always_comb begin
    wb_dat_o = '0;
    case (w_sel)
      REG_DATA:    wb_dat_o = {24'b0, r_rxdata};
      REG_STATUS:  wb_dat_o = {28'b0, r_frame_err, r_overrun, r_rx_valid, w_tx_busy};
      REG_SCRATCH: wb_dat_o = {16'b0, r_scratch};
      default:     wb_dat_o = '0;
    endcase
  end

  assign wb_ack_o = r_ack;
  assign tx       = r_tx;

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart with CLKS_PER_BIT = 2.
module tb_wb_uart;

  localparam int CPB   = 2;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_i, dat_o;
  logic        we, stb, cyc, ack, tx, rx;
  logic        rx_drv, rx_lb, loop_en;

  assign rx = loop_en ? rx_lb : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) rx_lb <= tx;

  wb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o),
    .wb_we_i  (we),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_ack_o (ack),
    .tx       (tx),
    .rx       (rx)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one transmit frame in flight, described by its
  // starting negedge count and byte; receive side as plain flags.
  int         cyc_n     = 0;
  bit         m_started = 0;
  int         m_start   = 0;
  logic [7:0] m_byte    = '0;
  logic [7:0] pend[$];
  logic [7:0] m_rxdata  = '0;
  bit         m_valid   = 0;
  bit         m_ovr     = 0;
  bit         m_ferr    = 0;

  function automatic logic exp_tx();
    int idx;
    int b;
    if (!m_started) return 1'b1;
    idx = cyc_n - m_start;
    if (idx < 0 || idx >= FRAME) return 1'b1;
    b = idx / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic bit m_busy();
    return m_started && ((cyc_n - m_start) < FRAME);
  endfunction

  function automatic logic [31:0] exp_status();
    return {28'b0, m_ferr, m_ovr, m_valid, m_busy()};
  endfunction

  function automatic void m_arrive(input logic [7:0] b, input bit stop_ok);
    if (m_valid) m_ovr = 1;
    m_valid  = 1;
    m_rxdata = b;
    if (!stop_ok) m_ferr = 1;
  endfunction

  always @(negedge clk) begin
    check("tx_line", {31'b0, tx}, {31'b0, exp_tx()});
    cyc_n++;
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    adr = a; dat_i = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("wr_ack", {31'b0, ack}, 32'd1);
    if (a[3:2] == 2'd0) begin
      // Busy is judged by the state before the committing edge.
      if (!(m_started && (cyc_n - m_start) <= FRAME)) begin
        m_started = 1;
        m_start   = cyc_n;
        m_byte    = d[7:0];
        if (loop_en) pend.push_back(d[7:0]);
      end
    end else if (a[3:2] == 2'd1) begin
      if (d[2]) m_ovr  = 0;
      if (d[3]) m_ferr = 0;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("rd_ack", {31'b0, ack}, 32'd1);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(32'h0000_9004, d);
    check(tag, d, exp_status());
  endtask

  task automatic check_rxdata(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = {24'b0, m_rxdata};
    bus_read(32'h0000_9000, d);
    m_valid = 0;
    check(tag, d, e);
  endtask

  task automatic settle();
    int g = 0;
    while (m_busy() && g < 200) begin
      @(posedge clk);
      g++;
    end
    repeat (10) @(posedge clk);
    #1;
    while (pend.size() > 0) m_arrive(pend.pop_front(), 1'b1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop_bit);
    logic v;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
      @(negedge clk) rx_drv = v;
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx_drv = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    m_arrive(b, stop_bit);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b1, b2;
    int          g;

    rst = 1'b1; adr = '0; dat_i = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_ack", {31'b0, ack}, 32'd0);
    adr = 32'h0000_9004; #1;
    check("rst_status", dat_o, 32'd0);
    adr = 32'h0000_9000; #1;
    check("rst_rxdata", dat_o, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Loopback of 0x66, byte visible within 24 cycles of the write
    bus_write(32'h0000_9000, 32'h66);
    adr = 32'h0000_9004;
    g = 0;
    #1;
    while (g < 24 && dat_o[1] !== 1'b1) begin
      @(posedge clk); #1;
      g++;
    end
    check("t2_rx_valid_in_24", {31'b0, dat_o[1]}, 32'd1);
    settle();
    check_rxdata("t2_rxdata");
    check_status("t2_status_clear");

    // Write while busy is dropped; busy lasts to the end of stop
    bus_write(32'h0000_9000, 32'hA5);
    repeat (3) @(posedge clk);
    check_status("t3_busy");
    bus_write(32'h0000_9000, 32'h3C);
    adr = 32'h0000_9004;
    #1;
    while ((cyc_n - m_start) < FRAME - 1) begin
      @(posedge clk); #1;
    end
    check("t3_busy_last", {31'b0, dat_o[0]}, 32'd1);
    @(posedge clk); #1;
    check("t3_busy_end", {31'b0, dat_o[0]}, 32'd0);
    settle();
    check_status("t3_status");
    check_rxdata("t3_rxdata");

    // Overrun, then write-1-to-clear
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    bus_write(32'h0000_9000, {24'b0, b1});
    settle();
    bus_write(32'h0000_9000, {24'b0, b2});
    settle();
    check_status("t4_overrun");
    bus_write(32'h0000_9004, 32'h4);
    check_status("t4_ovr_clr");
    check_rxdata("t4_rxdata");

    // Directly driven rx: bad stop bit, glitch, good frame
    loop_en = 1'b0;
    drive_frame(8'($urandom), 1'b0);
    check_status("t5_ferr");
    check_rxdata("t5_rxdata");
    bus_write(32'h0000_9004, 32'h8);
    check_status("t5_ferr_clr");
    @(negedge clk) rx_drv = 1'b0;
    @(negedge clk) rx_drv = 1'b1;
    repeat (20) @(posedge clk);
    check_status("t5_glitch");
    drive_frame(8'($urandom), 1'b1);
    check_status("t5_good_status");
    check_rxdata("t5_good_rxdata");
    loop_en = 1'b1;

    // Scratch, unused offset, back-to-back acks
    bus_write(32'h0000_9008, 32'hDEAD_BEEF);
    bus_read(32'h0000_9008, d);
    check("scratch", d, 32'h0000_BEEF);
    bus_write(32'h0000_900C, 32'hFFFF_FFFF);
    bus_read(32'h0000_900C, d);
    check("unused_off", d, 32'd0);
    @(negedge clk);
    adr = 32'h0000_9008; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("b2b_ack1", {31'b0, ack}, 32'd1);
    @(posedge clk); #1;
    check("b2b_ack2", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("b2b_ack_drop", {31'b0, ack}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 12; i++) begin
      bus_write(32'h0000_9000, {24'b0, 8'($urandom)});
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 15)) @(posedge clk);
        bus_write(32'h0000_9000, $urandom);
      end
      settle();
      case ($urandom_range(0, 2))
        0: check_rxdata("rnd_rxdata");
        1: check_status("rnd_status");
        default: begin
          bus_write(32'h0000_9004, {28'b0, 2'($urandom_range(0, 3)), 2'b0});
          check_status("rnd_w1c");
        end
      endcase
    end

    // Reset in the middle of a frame
    bus_write(32'h0000_9000, {24'b0, 8'($urandom) & 8'hF0});
    repeat (4) @(posedge clk);
    #2;
    check("t6_tx_low", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    m_started = 0; pend.delete(); m_valid = 0; m_ovr = 0; m_ferr = 0; m_rxdata = '0;
    #1;
    check("t6_tx_reset", {31'b0, tx}, 32'd1);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check_status("t6_status_rst");
    check_rxdata("t6_rxdata_rst");
    bus_read(32'h0000_9008, d);
    check("t6_scratch_rst", d, 32'd0);
    bus_write(32'h0000_9000, {24'b0, 8'($urandom)});
    settle();
    check_status("t6_status_after");
    check_rxdata("t6_rxdata_after");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
